// File: rtl/framebuffer_arbiter_if.sv
// framebuffer_arbiter_if: display, camera and RAM signal bundle for framebuffer_arbiter
// slave  : arbiter side (takes vga/cam requests and ram_rdata, drives RAM port and status)
// master : environment side (VGA timing, camera capture, RAM macro)
// drop_count/peak_level carry data only when FB_ARB_STATS_EN is defined, else they read 0.
interface framebuffer_arbiter_if #(
  parameter int DEPTH = 16,
  parameter int AW = 17,
  parameter int DW = 16
);
  localparam int LW = $clog2(DEPTH) + 1;
  logic vga_rd;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_data;
  logic vga_valid;
  logic cam_we;
  logic [AW-1:0] cam_addr;
  logic [DW-1:0] cam_data;
  logic cam_ready;
  logic flush;
  logic ovf_clr;
  logic overflow;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic ram_we;
  logic [DW-1:0] ram_rdata;
  logic [15:0] drop_count;
  logic [LW-1:0] peak_level;
  modport slave (
    input vga_rd, vga_addr, cam_we, cam_addr, cam_data, flush, ovf_clr, ram_rdata,
    output vga_data, vga_valid, cam_ready, overflow, ram_addr, ram_wdata, ram_we,
    drop_count, peak_level
  );
  modport master (
    output vga_rd, vga_addr, cam_we, cam_addr, cam_data, flush, ovf_clr, ram_rdata,
    input vga_data, vga_valid, cam_ready, overflow, ram_addr, ram_wdata, ram_we,
    drop_count, peak_level
  );
endinterface

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: shares one single-port frame-buffer RAM between display reads and buffered camera writes
// Ports: CLK25 (pixel clock), reset (sync, active-high), bus (framebuffer_arbiter_if.slave).
// Display reads always win the RAM port and return 3 cycles after vga_rd is sampled.
// Camera writes queue in a DEPTH-entry FIFO and drain on every non-read cycle, in order.
// Optional statistics (drop_count, peak_level) are built only when FB_ARB_STATS_EN is defined.
module framebuffer_arbiter #(
  parameter int DEPTH = 16,
  parameter int AW = 17,
  parameter int DW = 16
) (
  input logic CLK25,
  input logic reset,
  framebuffer_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state, next_state;
  logic [AW+DW-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count, count_next;
  logic full, push, pop, drop, rd_tag;
  logic [AW-1:0] addr_next;
  logic [DW-1:0] wdata_next;
  logic we_next;
  assign full = count == CW'(DEPTH);
  assign bus.cam_ready = !full;
  // flush swallows a same-cycle push without counting it as a drop
  assign push = bus.cam_we && !full && !bus.flush;
  assign drop = bus.cam_we && full && !bus.flush;
  always_ff @(posedge CLK25)
    if (reset) state <= IDLE;
    else state <= next_state;
  always_comb next_state = bus.vga_rd ? RD : (count != '0 ? WR : IDLE);
  always_comb begin
    pop = next_state == WR && !bus.flush;
    we_next = pop;
    addr_next = next_state == RD ? bus.vga_addr : (pop ? mem[rp][AW+DW-1:DW] : bus.ram_addr);
    wdata_next = pop ? mem[rp][DW-1:0] : bus.ram_wdata;
    count_next = bus.flush ? '0 : count + CW'(push) - CW'(pop);
  end
  always_ff @(posedge CLK25)
    if (push) mem[wp] <= {bus.cam_addr, bus.cam_data};
  // the registered RD state is the first stage of the read-valid pipe
  always_ff @(posedge CLK25)
    if (reset) begin
      count <= '0;
      wp <= '0;
      rp <= '0;
      bus.ram_addr <= '0;
      bus.ram_wdata <= '0;
      bus.ram_we <= 1'b0;
      rd_tag <= 1'b0;
      bus.vga_valid <= 1'b0;
      bus.vga_data <= '0;
      bus.overflow <= 1'b0;
    end else begin
      count <= count_next;
      wp <= bus.flush ? '0 : wp + PW'(push);
      rp <= bus.flush ? '0 : rp + PW'(pop);
      bus.ram_addr <= addr_next;
      bus.ram_wdata <= wdata_next;
      bus.ram_we <= we_next;
      rd_tag <= state == RD;
      bus.vga_valid <= rd_tag;
      bus.vga_data <= rd_tag ? bus.ram_rdata : bus.vga_data;
      bus.overflow <= drop | (bus.overflow & !bus.ovf_clr);
    end
`ifdef FB_ARB_STATS_EN
  logic [15:0] dc_base;
  logic [CW-1:0] pk_base;
  assign dc_base = bus.ovf_clr ? 16'd0 : bus.drop_count;
  assign pk_base = bus.ovf_clr ? '0 : bus.peak_level;
  always_ff @(posedge CLK25)
    if (reset) begin
      bus.drop_count <= '0;
      bus.peak_level <= '0;
    end else begin
      bus.drop_count <= (drop && dc_base != 16'hFFFF) ? dc_base + 16'd1 : dc_base;
      bus.peak_level <= count_next > pk_base ? count_next : pk_base;
    end
`else
  assign bus.drop_count = '0;
  assign bus.peak_level = '0;
`endif
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb_framebuffer_arbiter: directed plus randomized check of framebuffer_arbiter against a queue-based model
module tb_framebuffer_arbiter;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;
  framebuffer_arbiter_if bus();
  framebuffer_arbiter dut (.CLK25(clk), .reset(rst), .bus(bus));
  logic [15:0] ram [0:131071];
  always @(posedge clk) begin
    bus.ram_rdata <= ram[bus.ram_addr];
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
  end
  typedef struct {logic [16:0] a; logic [15:0] d;} wr_t;
  typedef struct {int due; logic [15:0] d;} rd_t;
  wr_t wq[$];
  rd_t rq[$];
  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  bit ov_m = 0;
  int drops_m = 0;
  int peak_m = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(bit rd, logic [16:0] ra, bit we, logic [16:0] wa, logic [15:0] wd, bit fl, bit clr, bit rs);
    bit ready, exp_we, exp_v;
    wr_t head;
    ready = wq.size() < DEPTH;
    if (!rs) chk("cam_ready", {31'd0, bus.cam_ready}, {31'd0, ready});
    rst = rs;
    bus.vga_rd = rd;
    bus.vga_addr = ra;
    bus.cam_we = we;
    bus.cam_addr = wa;
    bus.cam_data = wd;
    bus.flush = fl;
    bus.ovf_clr = clr;
    exp_we = !rs && !fl && !rd && wq.size() > 0;
    if (exp_we) head = wq[0];
    if (rd && !rs) rq.push_back('{cyc + 3, ra[15:0]});
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      wq.delete();
      rq.delete();
      ov_m = 0;
      drops_m = 0;
      peak_m = 0;
      chk("rst_ram_we", {31'd0, bus.ram_we}, 0);
      chk("rst_vga_valid", {31'd0, bus.vga_valid}, 0);
      chk("rst_overflow", {31'd0, bus.overflow}, 0);
      return;
    end
    chk("ram_we", {31'd0, bus.ram_we}, {31'd0, exp_we});
    if (exp_we) begin
      chk("ram_addr", {15'd0, bus.ram_addr}, {15'd0, head.a});
      chk("ram_wdata", {16'd0, bus.ram_wdata}, {16'd0, head.d});
      void'(wq.pop_front());
    end
    if (fl) wq.delete();
    else if (we && ready) wq.push_back('{wa, wd});
    if (clr) begin
      drops_m = 0;
      peak_m = 0;
    end
    if (we && !ready && !fl) begin
      ov_m = 1;
      if (drops_m < 65535) drops_m++;
    end else if (clr) ov_m = 0;
    if (wq.size() > peak_m) peak_m = wq.size();
    exp_v = rq.size() > 0 && rq[0].due == cyc;
    chk("vga_valid", {31'd0, bus.vga_valid}, {31'd0, exp_v});
    if (exp_v) begin
      chk("vga_data", {16'd0, bus.vga_data}, {16'd0, rq[0].d});
      void'(rq.pop_front());
    end
    chk("overflow", {31'd0, bus.overflow}, {31'd0, ov_m});
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, 0, 0, 0);
  endtask
  task automatic stats_chk(string tag);
`ifdef FB_ARB_STATS_EN
    chk({tag, "_drop_count"}, {16'd0, bus.drop_count}, drops_m);
    chk({tag, "_peak_level"}, {27'd0, bus.peak_level}, peak_m);
`else
    chk({tag, "_drop_count"}, {16'd0, bus.drop_count}, 0);
    chk({tag, "_peak_level"}, {27'd0, bus.peak_level}, 0);
`endif
  endtask
  initial begin
    bit burst;
    for (int i = 0; i < 131072; i++) ram[i] = i[15:0];
    repeat (3) step(0, '0, 0, '0, '0, 0, 0, 1);
    chk("rst_ram_addr", {15'd0, bus.ram_addr}, 0);
    chk("rst_ram_wdata", {16'd0, bus.ram_wdata}, 0);
    chk("rst_vga_data", {16'd0, bus.vga_data}, 0);
    stats_chk("rst");
    idle(2);
    for (int i = 0; i < 4; i++) step(1, 17'(i), 0, '0, '0, 0, 0, 0);
    idle(5);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 17'(100 + i), 16'(16'hA1 + i), 0, 0, 0);
    idle(5);
    for (int i = 0; i < 320; i++)
      step(1, 17'($urandom_range(0, 99)), i < 20, 17'(200 + i), 16'($urandom), 0, 0, 0);
    chk("full_overflow", {31'd0, bus.overflow}, 1);
    chk("full_cam_ready", {31'd0, bus.cam_ready}, 0);
    stats_chk("full");
`ifdef FB_ARB_STATS_EN
    chk("full_drop_count_4", {16'd0, bus.drop_count}, 4);
    chk("full_peak_16", {27'd0, bus.peak_level}, 16);
`endif
    idle(20);
    step(0, '0, 0, '0, '0, 0, 1, 0);
    stats_chk("clr");
    for (int i = 0; i < 5; i++) step(1, 17'($urandom_range(0, 99)), 1, 17'(300 + i), 16'($urandom), 0, 0, 0);
    step(1, 17'($urandom_range(0, 99)), 1, 17'(400), 16'h4444, 1, 0, 0);
    idle(6);
    stats_chk("flush");
    burst = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) burst = !burst;
      step(burst, 17'($urandom_range(0, 99)), $urandom_range(0, 1) == 1,
           17'($urandom_range(1000, 70000)), 16'($urandom),
           $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0, 0);
    end
    for (int i = 0; i < 6; i++) step(i % 2 == 0, 17'($urandom_range(0, 99)), 1, 17'(500 + i), 16'($urandom), 0, 0, 0);
    step(0, '0, 1, 17'(600), 16'h6666, 0, 0, 1);
    idle(6);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
